// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts an N-bit word on a valid/ready
// handshake and shifts it out MSB first, with framing strobes and optional even parity.
module piso_serializer #(
    parameter int N        = 6,
    parameter bit PAR_EN   = 1'b0,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         sout_first,
    output logic         sout_last
);
    localparam int F  = N + (PAR_EN ? 1 : 0);
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam logic [CW-1:0] LAST = CW'(F - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_sreg;
    logic            r_par;
    logic            r_ready;
    logic            r_sout;
    logic            r_valid;
    logic            r_first;
    logic            r_last;

    logic            w_accept;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_next_is_last;
    logic            w_next_is_par;

    assign w_accept       = din_valid & r_ready;
    assign w_cnt_inc      = r_cnt + CW'(1);
    assign w_next_is_last = (w_cnt_inc == LAST);
    // With parity enabled the final frame slot (cnt == F-1 == N) carries par.
    assign w_next_is_par  = PAR_EN && w_next_is_last;

    // Outputs are registered alongside the state so they are exact decodes
    // of the state/counter the bit is presented in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sreg  <= {N{IDLE_BIT}};
            r_par   <= 1'b0;
            r_ready <= 1'b1;
            r_sout  <= IDLE_BIT;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            // Reachable from IDLE or from the last SHIFT bit (gapless reload).
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_sreg  <= din;
            r_par   <= PAR_EN ? ^din : 1'b0;
            r_ready <= 1'b0;
            r_sout  <= din[N-1];
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (r_cnt != LAST) begin
                        r_sreg  <= {r_sreg[N-2:0], IDLE_BIT};
                        r_cnt   <= w_cnt_inc;
                        r_ready <= w_next_is_last;
                        r_sout  <= w_next_is_par ? r_par : r_sreg[N-2];
                        r_valid <= 1'b1;
                        r_first <= 1'b0;
                        r_last  <= w_next_is_last;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_sreg  <= {N{IDLE_BIT}};
                        r_ready <= 1'b1;
                        r_sout  <= IDLE_BIT;
                        r_valid <= 1'b0;
                        r_first <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_sout  <= IDLE_BIT;
                    r_valid <= 1'b0;
                    r_first <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = r_ready;
    assign sout       = r_sout;
    assign sout_valid = r_valid;
    assign sout_first = r_first;
    assign sout_last  = r_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a plain N=6 instance (idle level 0)
// and an N=6 even-parity instance (idle level 1) share clock, reset and din.
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] din;
    logic       v0, v1;
    logic       r0, s0, sv0, sf0, sl0;
    logic       r1, s1, sv1, sf1, sl1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_serializer #(.N(6), .PAR_EN(1'b0), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(v0), .din_ready(r0),
        .sout(s0), .sout_valid(sv0), .sout_first(sf0), .sout_last(sl0)
    );

    piso_serializer #(.N(6), .PAR_EN(1'b1), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(v1), .din_ready(r1),
        .sout(s1), .sout_valid(sv1), .sout_first(sf1), .sout_last(sl1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output vectors are {din_ready, sout, sout_valid, sout_first, sout_last}.
    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b10000) begin
            fails++;
            $display("FAIL reset_in0: got %b expected %b", got, 5'b10000);
        end
        got = {r1, s1, sv1, sf1, sl1};
        tests++;
        if (got !== 5'b11000) begin
            fails++;
            $display("FAIL reset_in1: got %b expected %b", got, 5'b11000);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            got = {r0, s0, sv0, sf0, sl0};
            tests++;
            if (got !== 5'b10000) begin
                fails++;
                $display("FAIL idle0 cyc%0d: got %b expected %b", c, got, 5'b10000);
            end
            got = {r1, s1, sv1, sf1, sl1};
            tests++;
            if (got !== 5'b11000) begin
                fails++;
                $display("FAIL idle1 cyc%0d: got %b expected %b", c, got, 5'b11000);
            end
        end
        $display("[TB] reset/idle done");
    endtask

    task automatic test_single();
        logic [5:0] w;
        logic [4:0] got, expv;
        w = 6'b101100;
        din = w; v0 = 1'b1;
        tests++;
        if (r0 !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: got %b expected 1", r0);
        end
        tick();
        v0 = 1'b0; din = 6'b111111;
        for (int i = 0; i < 6; i++) begin
            got  = {r0, s0, sv0, sf0, sl0};
            expv = {(i == 5), w[5-i], 1'b1, (i == 0), (i == 5)};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL single bit%0d: got %b expected %b", i + 1, got, expv);
            end
            tick();
        end
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b10000) begin
            fails++;
            $display("FAIL single_idle: got %b expected %b", got, 5'b10000);
        end
        $display("[TB] single word %b sent", w);
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits;
        logic [4:0]  got, expv;
        bits = 12'b111000_010101;
        din = 6'b111000; v0 = 1'b1;
        tick();
        din = 6'b010101;
        for (int i = 0; i < 12; i++) begin
            got  = {r0, s0, sv0, sf0, sl0};
            expv = {(i == 5 || i == 11), bits[11-i], 1'b1, (i == 0 || i == 6), (i == 5 || i == 11)};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL b2b bit%0d: got %b expected %b", i + 1, got, expv);
            end
            if (i == 11) v0 = 1'b0;
            tick();
        end
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b10000) begin
            fails++;
            $display("FAIL b2b_idle: got %b expected %b", got, 5'b10000);
        end
        $display("[TB] back-to-back 111000,010101 sent");
    endtask

    task automatic test_parity();
        logic [13:0] bits;
        logic [4:0]  got, expv;
        // 101100 has three ones -> parity 1; 110011 has four -> parity 0.
        bits = 14'b1011001_1100110;
        din = 6'b101100; v1 = 1'b1;
        tick();
        din = 6'b110011;
        for (int i = 0; i < 14; i++) begin
            got  = {r1, s1, sv1, sf1, sl1};
            expv = {(i == 6 || i == 13), bits[13-i], 1'b1, (i == 0 || i == 7), (i == 6 || i == 13)};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL parity bit%0d: got %b expected %b", i + 1, got, expv);
            end
            if (i == 13) v1 = 1'b0;
            tick();
        end
        got = {r1, s1, sv1, sf1, sl1};
        tests++;
        if (got !== 5'b11000) begin
            fails++;
            $display("FAIL parity_idle: got %b expected %b", got, 5'b11000);
        end
        $display("[TB] parity frames 101100,110011 sent");
    endtask

    task automatic test_reset_mid();
        logic [5:0] w;
        logic [4:0] got, expv;
        din = 6'b101100; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b01100) begin
            fails++;
            $display("FAIL midrst_pre bit3: got %b expected %b", got, 5'b01100);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b10000) begin
            fails++;
            $display("FAIL midrst_async: got %b expected %b", got, 5'b10000);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        w = 6'b000001;
        din = w; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            got  = {r0, s0, sv0, sf0, sl0};
            expv = {(i == 5), w[5-i], 1'b1, (i == 0), (i == 5)};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL midrst_after bit%0d: got %b expected %b", i + 1, got, expv);
            end
            tick();
        end
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b10000) begin
            fails++;
            $display("FAIL midrst_idle: got %b expected %b", got, 5'b10000);
        end
        $display("[TB] mid-frame reset then 000001 sent");
    endtask

    task automatic test_din_hold();
        logic [11:0] bits;
        logic [4:0]  got, expv;
        bits = 12'b000111_110010;
        din = 6'b000111; v0 = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            got  = {r0, s0, sv0, sf0, sl0};
            expv = {(i == 5 || i == 11), bits[11-i], 1'b1, (i == 0 || i == 6), (i == 5 || i == 11)};
            tests++;
            if (got !== expv) begin
                fails++;
                $display("FAIL dinhold bit%0d: got %b expected %b", i + 1, got, expv);
            end
            if (i < 5) din = 6'($urandom);
            else if (i == 5) din = 6'b110010;
            else if (i < 11) din = 6'($urandom);
            else v0 = 1'b0;
            tick();
        end
        got = {r0, s0, sv0, sf0, sl0};
        tests++;
        if (got !== 5'b10000) begin
            fails++;
            $display("FAIL dinhold_idle: got %b expected %b", got, 5'b10000);
        end
        $display("[TB] din changes while busy ignored");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_din_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that drives the serial input of the team's generic shift-register delay lines and deserializers. It accepts an N-bit word over a valid/ready handshake and emits it one bit per clock, MSB first, with framing strobes and an optional even-parity bit. Back-to-back words are sent with no idle gap.

## Interface
- N, default 6: data word width, N >= 2.
- PAR_EN, default 0: 1 appends an even-parity bit after the data bits, so the frame length F = N+1. 0 means F = N.
- IDLE_BIT, default 0: level driven on sout whenever no frame bit is being sent.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- din, input, N: parallel word to transmit.
- din_valid, input, 1: din is offered.
- din_ready, output, 1: the block accepts din this cycle.
- sout, output, 1: serial data.
- sout_valid, output, 1: sout carries a frame bit.
- sout_first, output, 1: sout carries the first bit of a frame, din[N-1].
- sout_last, output, 1: sout carries the final bit of a frame (the parity bit if PAR_EN=1, else din[0]).

## Operation
- State machine with two states, IDLE and SHIFT. Bit counter cnt, width clog2(F), counts 0..F-1.
- Word acceptance:
  - A word is accepted on a rising edge where din_valid & din_ready.
  - din_ready = (state==IDLE) | (state==SHIFT & cnt==F-1).
  - din_ready is a function of registered state only and never depends on din_valid.
- IDLE, on accept:
  - Shift register sreg <= din.
  - If PAR_EN, par <= ^din.
  - cnt <= 0, go to SHIFT.
- IDLE, no accept: remain in IDLE.
- SHIFT with cnt < F-1: shift sreg left by one (fill with IDLE_BIT), cnt <= cnt+1.
- SHIFT with cnt == F-1 (last bit):
  - If a word is accepted, reload sreg/par, cnt <= 0, stay in SHIFT. This gives a gapless next frame.
  - Otherwise go to IDLE.
- Output mux:
  - In SHIFT with cnt < N: sout = sreg[N-1].
  - In SHIFT with cnt == N (PAR_EN=1 only): sout = par.
  - In IDLE: sout = IDLE_BIT.
- Output strobes:
  - sout_valid = (state==SHIFT).
  - sout_first = SHIFT & cnt==0.
  - sout_last = SHIFT & cnt==F-1.
- Even parity: the total number of ones across the N data bits plus the parity bit is even.
- din is sampled only at the accept edge. Changes to din at any other time have no effect.
- din_valid while din_ready=0 is ignored. The upstream must hold the word; nothing is queued.

## Timing
- Reset values: state=IDLE, cnt=0, sreg=all IDLE_BIT, par=0.
- Output values during and after reset: din_ready=1, sout=IDLE_BIT, sout_valid=0, sout_first=0, sout_last=0.
- Latency: for a word accepted at edge k, the first bit is on sout during the cycle after edge k. The last bit is on sout during cycle k+F.
- Throughput: one word per F cycles when din_valid is held high. sout_valid stays 1 continuously.
- Idle return: with no new word, sout_valid falls at the edge that ends the last bit.
- Reset mid-frame: asserting rst_n low aborts the frame immediately and asynchronously. All outputs go to their reset values. No partial bits resume after release.
- Reset release: the first accept can occur on the first rising edge after rst_n goes high.

## Test plan
- Reset, then hold din_valid=0 for 10 cycles -> din_ready=1, sout=IDLE_BIT, sout_valid=0 throughout.
- N=6, PAR_EN=0, single word din=6'b101100 -> sout = 1,0,1,1,0,0 on cycles 1..6 after accept. sout_first on cycle 1 only, sout_last on cycle 6 only. Back to IDLE at cycle 7.
- Back-to-back with din_valid held high: 6'b111000 then 6'b010101 -> 12 consecutive valid bits 1,1,1,0,0,0,0,1,0,1,0,1 with no gap. din_ready high only in the accept cycle and on cycles 6 and 12.
- PAR_EN=1, N=6: din=6'b101100 -> 7 bits 1,0,1,1,0,0,1 with the parity bit flagged by sout_last. Then din=6'b110011 -> final bit 0.
- Assert rst_n low during bit 3 of a frame -> sout_valid=0 and sout=IDLE_BIT within the same cycle, without waiting for a clock edge. After release, a new word 6'b000001 is sent cleanly: 0,0,0,0,0,1.
- Change din while in SHIFT with din_ready=0, holding din_valid=1 -> transmitted bits are unaffected. The new value is accepted only at the cnt==F-1 edge.
